// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: debounced seven-segment bus capture with hex decode and up/down direction tracking
module seg7_capture_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [6:0] seg_in,
  output logic [3:0] value,
  output logic       value_valid,
  output logic       code_err,
  output logic       dir_up,
  output logic       dir_down,
  output logic [3:0] run_len
);
  typedef enum logic [1:0] {EMPTY, NONE, UP, DOWN} dir_t;
  localparam logic [6:0] SEGS [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  dir_t       r_state, w_state_nxt;
  logic [3:0] r_value, r_run, w_run_nxt, w_digit, w_d;
  logic [6:0] r_s, r_last, w_in;
  logic [7:0] r_cnt;
  logic       r_have, r_vv, r_ce, w_legal, w_accept;
  assign w_in        = seg_in ^ {7{SEG_ACTIVE_LOW}};
  assign w_accept    = (r_cnt == STABLE) && (!r_have || r_s != r_last);
  assign w_d         = w_digit - r_value;
  assign value       = r_value;
  assign value_valid = r_vv;
  assign code_err    = r_ce;
  assign dir_up      = r_state == UP;
  assign dir_down    = r_state == DOWN;
  assign run_len     = r_run;
  always_comb begin
    w_legal = 1'b0;
    w_digit = 4'h0;
    for (int i = 0; i < 16; i++)
      if (r_s == SEGS[i]) begin
        w_legal = 1'b1;
        w_digit = 4'(i);
      end
  end
  // an illegal pattern breaks the sequence, so the next legal value only re-seeds history
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    if (w_accept && !w_legal) begin
      w_state_nxt = EMPTY;
      w_run_nxt   = 4'd0;
    end else if (w_accept) begin
      if (r_state == EMPTY || (w_d != 4'd1 && w_d != 4'd15)) begin
        w_state_nxt = NONE;
        w_run_nxt   = 4'd0;
      end else begin
        w_state_nxt = (w_d == 4'd1) ? UP : DOWN;
        w_run_nxt   = (r_state != w_state_nxt) ? 4'd1 : (r_run == 4'd15) ? r_run : r_run + 4'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_s     <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_have  <= 1'b0;
      r_value <= '0;
      r_vv    <= 1'b0;
      r_ce    <= 1'b0;
      r_state <= EMPTY;
      r_run   <= '0;
    end else begin
      r_s     <= w_in;
      r_cnt   <= (w_in != r_s) ? 8'd1 : (r_cnt == STABLE) ? r_cnt : r_cnt + 8'd1;
      r_vv    <= w_accept && w_legal;
      r_ce    <= w_accept && !w_legal;
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      if (w_accept) begin
        r_last <= r_s;
        r_have <= 1'b1;
      end
      if (w_accept && w_legal) r_value <= w_digit;
    end
  end
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb_seg7_capture_decoder: directed vectors against an active-high and an active-low instance
module tb_seg7_capture_decoder;
  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic       clk = 1'b0, clr_n;
  logic [6:0] seg0, seg1;
  logic [3:0] value0, run0, value1, run1;
  logic       vv0, ce0, up0, dn0, vv1, ce1, up1, dn1;
  int n_chk = 0, n_miss = 0, vv_cnt = 0, ce_cnt = 0, vv1_cnt = 0;
  always #5 clk = ~clk;
  seg7_capture_decoder #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .clr_n(clr_n), .seg_in(seg0), .value(value0), .value_valid(vv0),
    .code_err(ce0), .dir_up(up0), .dir_down(dn0), .run_len(run0));
  seg7_capture_decoder #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .clr_n(clr_n), .seg_in(seg1), .value(value1), .value_valid(vv1),
    .code_err(ce1), .dir_up(up1), .dir_down(dn1), .run_len(run1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (vv0) vv_cnt++;
      if (ce0) ce_cnt++;
      if (vv1) vv1_cnt++;
    end
  endtask
  task automatic hold(input logic [6:0] p, input int n);
    seg0 = p;
    step(n);
  endtask
  task automatic accept(input string tag, input logic [6:0] p, input logic [3:0] v,
                        input logic up, input logic dn, input logic [3:0] run);
    vv_cnt = 0;
    hold(p, 8);
    chk({tag, "_pulses"}, vv_cnt, 1);
    chk({tag, "_value"}, value0, v);
    chk({tag, "_dir"}, {up0, dn0}, {up, dn});
    chk({tag, "_run"}, run0, run);
  endtask
  initial begin
    clr_n = 1'b0;
    seg0  = 7'h00;
    seg1  = 7'h7F;
    step(2);
    chk("rst_outs", {value0, vv0, ce0, up0, dn0, run0}, 0);
    chk("rst_outs_al", {value1, vv1, ce1, up1, dn1, run1}, 0);
    clr_n = 1'b1;
    seg0  = 7'h3F;
    vv_cnt = 0;
    step(4);
    chk("latency_early", vv_cnt, 0);
    step(1);
    chk("latency_pulse", vv0, 1'b1);
    chk("first_value", {value0, up0, dn0, run0}, 0);
    step(10);
    chk("held_once", vv_cnt, 1);
    clr_n = 1'b0;
    step(1);
    clr_n = 1'b1;
    accept("cnt1", 7'h06, 4'h1, 1'b0, 1'b0, 4'd0);
    accept("cnt2", 7'h5B, 4'h2, 1'b1, 1'b0, 4'd1);
    accept("cnt3", 7'h4F, 4'h3, 1'b1, 1'b0, 4'd2);
    accept("cnt4", 7'h66, 4'h4, 1'b1, 1'b0, 4'd3);
    accept("jumpF", 7'h71, 4'hF, 1'b0, 1'b0, 4'd0);
    accept("wrapup", 7'h3F, 4'h0, 1'b1, 1'b0, 4'd1);
    accept("wrapdn", 7'h71, 4'hF, 1'b0, 1'b1, 4'd1);
    accept("to5", 7'h6D, 4'h5, 1'b0, 1'b0, 4'd0);
    vv_cnt = 0;
    ce_cnt = 0;
    hold(7'h7F, 2);
    hold(7'h6D, 10);
    chk("glitch_events", {vv_cnt[7:0], ce_cnt[7:0]}, 0);
    chk("glitch_value", value0, 4'h5);
    hold(7'h49, 8);
    chk("illegal_err", ce_cnt, 1);
    chk("illegal_novv", vv_cnt, 0);
    chk("illegal_outs", {value0, up0, dn0, run0}, {4'h5, 6'd0});
    hold(7'h49, 8);
    chk("illegal_once", ce_cnt, 1);
    accept("after_err", 7'h7D, 4'h6, 1'b0, 1'b0, 4'd0);
    accept("down1", 7'h6D, 4'h5, 1'b0, 1'b1, 4'd1);
    vv_cnt = 0;
    for (int i = 1; i <= 16; i++) hold(SEG[(5 + i) % 16], 8);
    chk("sat_pulses", vv_cnt, 16);
    chk("sat_run", {up0, run0}, {1'b1, 4'd15});
    chk("sat_value", value0, 4'h5);
    seg1 = 7'h40;
    step(2);
    #2 clr_n = 1'b0;
    #1;
    chk("async_rst", {value0, vv0, ce0, up0, dn0, run0}, 0);
    chk("async_rst_al", {value1, vv1, ce1, up1, dn1, run1}, 0);
    @(negedge clk);
    clr_n = 1'b1;
    vv1_cnt = 0;
    step(4);
    chk("al_window", vv1_cnt, 0);
    step(1);
    chk("al_pulse", {vv1, ce1}, 2'b10);
    chk("al_value", value1, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
    $finish;
  end
endmodule
